// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built from one 4-bit ripple-carry slice,
// stepped one nibble per clock, least-significant nibble first.

module four_bit_rca (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[4];
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 overflow,
    output logic                 zero,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic          carry_reg;
    logic [IW-1:0] idx;
    logic [W-1:0]  sum_reg;
    logic          cout_reg;
    logic          ovf_reg;
    logic          zero_reg;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_cout;
    logic [W-1:0]  sum_next;
    logic          last;

    four_bit_rca u_rca (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry_reg),
        .S    (nib_s),
        .Cout (nib_cout)
    );

    // Operand slice and the sum as it will look after this edge's write.
    always_comb begin
        nib_a    = a_reg[{idx, 2'b00} +: 4];
        nib_b    = b_reg[{idx, 2'b00} +: 4] ^ {4{sub_reg}};
        sum_next = sum_reg;
        sum_next[{idx, 2'b00} +: 4] = nib_s;
        last     = (idx == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        sub_reg   <= sub;
                        carry_reg <= sub;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= nib_cout;
                    idx       <= idx + 1'b1;
                    if (last) begin
                        cout_reg <= nib_cout;
                        ovf_reg  <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg))
                                 && (sum_next[W-1] != a_reg[W-1]);
                        zero_reg <= (sum_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;
    assign zero     = zero_reg;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed checks of the nibble-serial adder
// against an arithmetic reference model.

module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         busy;

    int n_tests;
    int n_fail;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, output logic [W-1:0] r,
                         output logic c, output logic v, output logic z);
        longint ua, ub, full, sa, sb, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
        sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
        if (s) begin
            full = ua + (2 ** W - 1 - ub) + 1;
            sr   = sa - sb;
        end else begin
            full = ua + ub;
            sr   = sa + sb;
        end
        r = W'(full % (2 ** W));
        c = (full >= 2 ** W);
        v = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
        z = (r == '0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int hold);
        logic [W-1:0] er;
        logic ec, ev, ez;
        logic [W-1:0] held;
        int n;
        model(a, b, s, er, ec, ev, ez);
        wait_ready();
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
            sub  = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(N));
        check("sum", 32'(sum), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        check("overflow", 32'(overflow), 32'(ev));
        check("zero", 32'(zero), 32'(ez));
        held = sum;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'(held));
            check("bp_flags", 32'({cout, overflow, zero}),
                  32'({ec, ev, ez}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic         bs [3];

    initial begin
        logic [W-1:0] er;
        logic ec, ev, ez;
        logic [W-1:0] exp_q [$];
        int cyc, k, got, last_t;
        logic acc;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", 32'({sum, cout, overflow, zero}), 32'd0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0FCD, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 0);
        run_op(16'h0000, 16'h8000, 1'b1, 0);
        run_op(16'hABCD, 16'h1111, 1'b0, 3);

        // Abort in the middle of RUN
        wait_ready();
        op_a     = 16'hFFFF;
        op_b     = 16'hFFFF;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 30; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));

        // Back-to-back with both handshakes held high
        for (int i = 0; i < 3; i++) begin
            ba[i] = W'($urandom);
            bb[i] = W'($urandom);
            bs[i] = 1'($urandom);
        end
        k         = 0;
        got       = 0;
        cyc       = 0;
        last_t    = -1;
        op_a      = ba[0];
        op_b      = bb[0];
        sub       = bs[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 3 && cyc < 60) begin
            if (out_valid) begin
                if (exp_q.size() > 0)
                    check("b2b_sum", 32'(sum), 32'(exp_q.pop_front()));
                else
                    check("b2b_spurious", 32'(out_valid), 32'd0);
                if (last_t >= 0)
                    check("b2b_spacing", 32'(cyc - last_t), 32'(N + 2));
                last_t = cyc;
                got++;
            end
            acc = in_ready && in_valid;
            if (acc) begin
                model(ba[k], bb[k], bs[k], er, ec, ev, ez);
                exp_q.push_back(er);
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                k++;
                if (k < 3) begin
                    op_a = ba[k];
                    op_b = bb[k];
                    sub  = bs[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", 32'(got), 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
